// File: rtl/mem_dma.sv
// mem_dma: block copy / fill engine driving a dual-port word memory.
//
// Port 0 of the memory is used only for reads and port 1 only for writes.
// A request is sampled in IDLE on iw_start. Copy moves iw_len words from
// iw_src to iw_dst, and fill writes iw_pattern to iw_len words at iw_dst.
// All address arithmetic wraps modulo the memory depth (4096 words).
//
// Ports
//   iw_clk, iw_rst          clock, synchronous active-high reset
//   iw_start                request strobe (sampled in IDLE only)
//   iw_mode                 0 = copy, 1 = fill
//   iw_src, iw_dst          source / destination base addresses
//   iw_len                  word count 0..4096 (larger values are rejected)
//   iw_pattern              fill word
//   or_busy                 transfer in progress
//   or_done                 one-cycle completion pulse
//   or_err                  one-cycle reject pulse, coincident with or_done
//   or_we, or_addr,         memory port controls; index 0 = read port,
//   or_wdata                index 1 = write port
//   iw_rdata                memory read data; only index 0 is used, and it
//                           reflects or_addr[0] by the following clock edge

package mem_dma_pkg;
    localparam int HBIT_ADDR = 11;  // 4096-word memory
    localparam int HBIT_DATA = 23;  // 24-bit words
endpackage

module mem_dma
    import mem_dma_pkg::*;
(
    input  logic                 iw_clk,
    input  logic                 iw_rst,
    input  logic                 iw_start,
    input  logic                 iw_mode,
    input  logic [HBIT_ADDR:0]   iw_src,
    input  logic [HBIT_ADDR:0]   iw_dst,
    input  logic [HBIT_ADDR+1:0] iw_len,
    input  logic [HBIT_DATA:0]   iw_pattern,
    output logic                 or_busy,
    output logic                 or_done,
    output logic                 or_err,
    output logic [0:1]           or_we,
    output logic [HBIT_ADDR:0]   or_addr  [0:1],
    output logic [HBIT_DATA:0]   or_wdata [0:1],
    input  logic [HBIT_DATA:0]   iw_rdata [0:1]
);

    localparam int AW = HBIT_ADDR + 1;
    localparam int LW = HBIT_ADDR + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_COPY,
        S_FILL,
        S_FIN
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       src_q, src_d;
    logic [AW-1:0]       dst_q, dst_d;
    logic [LW-1:0]       len_q, len_d;
    logic [HBIT_DATA:0]  pat_q, pat_d;
    logic                rej_q, rej_d;
    logic [LW-1:0]       cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                we1_q, we1_d;
    logic [AW-1:0]       raddr_q, raddr_d;
    logic [AW-1:0]       waddr_q, waddr_d;
    logic [HBIT_DATA:0]  wdata_q, wdata_d;

    logic [AW-1:0]       diff;
    logic                reject;
    logic                last;
    logic [HBIT_DATA:0]  unused_rdata1;

    assign unused_rdata1 = iw_rdata[1];

    // Forward overlap: the destination starts inside the source window, so
    // an ascending copy would overwrite source words before reading them.
    assign diff   = iw_dst - iw_src;
    assign reject = (iw_len > LW'(4096)) ||
                    (!iw_mode && (diff != '0) && ({1'b0, diff} < iw_len));

    // cnt_q counts writes already issued; len_q is nonzero in COPY/FILL.
    assign last = (cnt_q == len_q - LW'(1));

    // State and output registers
    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            pat_q   <= '0;
            rej_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            we1_q   <= 1'b0;
            raddr_q <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            pat_q   <= pat_d;
            rej_q   <= rej_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            we1_q   <= we1_d;
            raddr_q <= raddr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (iw_start) begin
                    if (reject || (iw_len == '0)) state_d = S_FIN;
                    else if (iw_mode)             state_d = S_FILL;
                    else                          state_d = S_PRIME;
                end
            end
            S_PRIME: state_d = S_COPY;
            S_COPY:  if (last) state_d = S_FIN;
            S_FILL:  if (last) state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        pat_d   = pat_q;
        rej_d   = rej_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        we1_d   = we1_q;
        raddr_d = raddr_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                we1_d = 1'b0;
                if (iw_start) begin
                    src_d  = iw_src;
                    dst_d  = iw_dst;
                    len_d  = iw_len;
                    pat_d  = iw_pattern;
                    rej_d  = reject;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                end
            end
            S_PRIME: begin
                raddr_d = src_q;
            end
            S_COPY: begin
                // Write the word fetched by the previous read address.
                we1_d   = 1'b1;
                waddr_d = dst_q + cnt_q[AW-1:0];
                wdata_d = iw_rdata[0];
                cnt_d   = cnt_q + LW'(1);
                if (!last) raddr_d = src_q + cnt_q[AW-1:0] + AW'(1);
            end
            S_FILL: begin
                we1_d   = 1'b1;
                waddr_d = dst_q + cnt_q[AW-1:0];
                wdata_d = pat_q;
                cnt_d   = cnt_q + LW'(1);
            end
            S_FIN: begin
                we1_d  = 1'b0;
                done_d = 1'b1;
                err_d  = rej_q;
                busy_d = 1'b0;
            end
            default: begin
                we1_d  = 1'b0;
                busy_d = 1'b0;
            end
        endcase
    end

    assign or_busy     = busy_q;
    assign or_done     = done_q;
    assign or_err      = err_q;
    assign or_we[0]    = 1'b0;
    assign or_we[1]    = we1_q;
    assign or_addr[0]  = raddr_q;
    assign or_addr[1]  = waddr_q;
    assign or_wdata[0] = '0;
    assign or_wdata[1] = wdata_q;

endmodule

// File: doc/mem_dma.md
# mem_dma

Block copy/fill engine that acts as the initiator on the dual-port word memory's interface. It drives both memory ports directly: port 0 is used only for reads and port 1 only for writes. It moves `len` words from `src` to `dst`, or fills `len` words at `dst` with a constant pattern, under a start/busy/done handshake from the core or control logic. It sits between the control path and the memory in place of the core's memory-port mux whenever a bulk transfer is running.

## Interface
Parameters:
- none; widths come from `src/sizes.vh` (`HBIT_ADDR`, `HBIT_DATA`), memory depth 4096 words.

Ports:
- `iw_clk` in 1: the single clock; every register updates on its rising edge.
- `iw_rst` in 1: synchronous, active-high reset.
- `iw_start` in 1: request; sampled only in IDLE.
- `iw_mode` in 1: 0 = copy, 1 = fill.
- `iw_src` in `HBIT_ADDR+1`: source base address (copy only).
- `iw_dst` in `HBIT_ADDR+1`: destination base address.
- `iw_len` in `HBIT_ADDR+2`: word count, 0..4096.
- `iw_pattern` in `HBIT_DATA+1`: fill word.
- `or_busy` out 1: transfer in progress.
- `or_done` out 1: one-cycle completion pulse.
- `or_err` out 1: one-cycle pulse, coincident with `or_done`, when the request is rejected.
- `or_we` out [0:1]: memory write enables. `or_we[0]` is tied to 0.
- `or_addr` out [0:1] x `HBIT_ADDR+1`: memory addresses.
- `or_wdata` out [0:1] x `HBIT_DATA+1`: memory write data. `or_wdata[0]` is tied to 0.
- `iw_rdata` in [0:1] x `HBIT_DATA+1`: memory read data. Only `iw_rdata[0]` is used; it is valid one cycle after the address is presented.

## Operation
- All outputs are registered.
- Reset value of every output is 0. Reset forces state IDLE.
- States: IDLE, PRIME, COPY, FILL, FIN.
- IDLE: `iw_start`=1 latches all request inputs and sets `or_busy`=1. The next state is:
  - FIN with `or_err`=1 if any of these hold:
    - `len` > 4096;
    - mode is copy and d = (dst − src) mod 4096 satisfies 0 < d < len (forward overlap).
  - FIN with `or_err`=0 if `len`=0.
  - FILL if mode is fill.
  - PRIME if mode is copy.
- PRIME: present `src` on `or_addr[0]`, then go to COPY.
- COPY, per cycle:
  - advance the read address;
  - present a write of the word read one cycle earlier, with `or_we[1]`=1, `or_addr[1]`=dst+i, `or_wdata[1]`=`iw_rdata[0]`;
  - stop issuing reads after read N−1;
  - after write N−1, go to FIN.
- FILL: one write per cycle, with `or_addr[1]`=dst+i and `or_wdata[1]`=pattern, for i=0..N−1. Then go to FIN.
- FIN:
  - clear `or_we[1]`;
  - pulse `or_done` (and `or_err` if the request was rejected) for one cycle;
  - clear `or_busy`;
  - return to IDLE.
- Address arithmetic is modulo 4096. A transfer crossing 4095 continues at 0.
- `iw_start` while busy is ignored and is not queued. Request inputs may change freely after acceptance.
- Backward overlap (d ≥ len, or dst before src) and d=0 are legal. An ascending copy is correct in those cases.
- Reset mid-transfer aborts at once:
  - `or_we[1]` is 0 from the reset edge on;
  - no `or_done` is issued;
  - words already written stay written.

## Timing
- E0 is the edge that samples `iw_start`=1 in IDLE. `or_busy` is 1 from E0.
- Copy of N≥1 words:
  - read of src+k presented after E(k+1);
  - write of dst+k presented after E(k+2) and committed by memory at E(k+3);
  - `or_done` is high between E(N+2) and E(N+3);
  - `or_busy` is low from E(N+2).
- Fill of N≥1 words:
  - write k presented after E(k+1);
  - `or_done` is high after E(N+1).
- `len`=0 or rejected request: `or_done` is high after E1 and no memory operation is presented.
- A new request is accepted no earlier than the edge after `or_done`. Back-to-back throughput is 1 word per cycle plus 3 cycles of overhead for copy and 2 for fill.

## Test plan
- Fill: dst=0x010, len=4, pattern=0xA5A5A5 → `or_we[1]` high exactly 4 cycles with addr 0x010..0x013. `or_done` arrives 5 cycles after E0. Memory readback gives 0xA5A5A5 ×4.
- Copy: src=0x000 holding 1,2,3, dst=0x100, len=3 → 0x100..0x102 = 1,2,3. `or_done` arrives at E5. `or_err`=0.
- Wrap: fill dst=0xFFE, len=4 → words 0xFFE, 0xFFF, 0x000, 0x001 written. Nothing else changes.
- Rejects:
  - copy src=0x020, dst=0x022, len=4 → `or_done` and `or_err` at E1, no writes;
  - len=0 → `or_done` at E1, `or_err`=0;
  - len=4097 → `or_err`=1.
- Backward overlap: copy src=0x022, dst=0x020, len=4 → correct shifted data and no error. An `iw_start` pulse mid-transfer is ignored.
- Reset: assert `iw_rst` during the third write of a len=8 fill → outputs 0 on the next cycle. Only the first 2–3 words are modified. No `or_done`.
